givens_rotator: RTL and testbench

- Consumes the sin/cos pair and the single-cycle `ready_for_givens` strobe produced by the angle stage.
- Applies the Jacobi/Givens plane rotation to a stream of N element pairs (a_p, a_q) taken from rows/columns p and q of the working matrix.
- Returns the rotated pairs to the matrix-update logic over a valid/ready stream.
- Sits between the angle stage and the matrix RAM write-back path.

---
 rtl/givens_rotator_if.sv | 27 ++
 rtl/givens_rotator.sv | 164 ++++++++++++++++
 tb/tb_givens_rotator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/givens_rotator_if.sv
// rtl/givens_rotator_if.sv - element-pair input and rotated-pair output streams of the Givens rotator
interface givens_rotator_if #(
   parameter int N      = 8,
   parameter int DATA_W = 32
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_p;
   logic signed [DATA_W-1:0] in_q;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_p;
   logic signed [DATA_W-1:0] out_q;
   logic [IW-1:0]            out_idx;

   modport master (
      output in_valid, in_p, in_q, out_ready,
      input  in_ready, out_valid, out_p, out_q, out_idx
   );

   modport slave (
      input  in_valid, in_p, in_q, out_ready,
      output in_ready, out_valid, out_p, out_q, out_idx
   );
endinterface

// File: rtl/givens_rotator.sv
// rtl/givens_rotator.sv - Jacobi/Givens plane rotation of N element pairs per latched sin/cos
module givens_rotator #(
   parameter int N       = 8,
   parameter int DATA_W  = 32,
   parameter int CS_FRAC = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [31:0] sin,
   input  logic signed [31:0] cos,
   input  logic               ready_for_givens,
   givens_rotator_if.slave    st,
   output logic               busy,
   output logic               done,
   output logic               sat_flag
);
   localparam int PW = DATA_W + 32;
   localparam int SW = PW + 1;
   localparam int CW = $clog2(N + 1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] N_CNT    = CW'(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic signed [SW-1:0] RND = {{(SW-CS_FRAC){1'b0}}, 1'b1, {(CS_FRAC-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_ROTATE, ST_DONE} state_t;

   state_t                   state_q, state_d;
   logic signed [31:0]       s_q, s_d, c_q, c_d;
   logic [CW-1:0]            in_cnt_q, in_cnt_d;
   logic [IW-1:0]            out_idx_q, out_idx_d;
   logic                     sat_q, sat_d;
   logic                     v1_q, v1_d, out_valid_q, out_valid_d;
   logic signed [PW-1:0]     cp_q, cp_d, sq_q, sq_d, sp_q, sp_d, cq_q, cq_d;
   logic signed [DATA_W-1:0] out_p_q, out_p_d, out_q_q, out_q_d;
   logic                     stall, in_ready_w, in_hs, out_hs;
   logic signed [PW-1:0]     c_x, s_x, p_x, q_x;
   logic signed [SW-1:0]     sum_p, sum_q;
   logic [DATA_W:0]          res_p, res_q;

   // Result is {clamped, value}: round half up, drop CS_FRAC bits, clamp to DATA_W.
   function automatic logic [DATA_W:0] round_sat(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] r;
      r = (v + RND) >>> CS_FRAC;
      if (!r[SW-1] && (r[SW-2:DATA_W-1] != '0))
         return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
      if (r[SW-1] && (r[SW-2:DATA_W-1] != '1))
         return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      return {1'b0, r[DATA_W-1:0]};
   endfunction

   always_comb begin
      stall      = out_valid_q && !st.out_ready;
      in_ready_w = (state_q == ST_ROTATE) && (in_cnt_q < N_CNT) && !stall;
      in_hs      = st.in_valid && in_ready_w;
      out_hs     = out_valid_q && st.out_ready;
      c_x        = PW'(c_q);
      s_x        = PW'(s_q);
      p_x        = PW'(st.in_p);
      q_x        = PW'(st.in_q);
      sum_p      = SW'(cp_q) - SW'(sq_q);
      sum_q      = SW'(sp_q) + SW'(cq_q);
      res_p      = round_sat(sum_p);
      res_q      = round_sat(sum_q);

      state_d     = state_q;
      s_d         = s_q;
      c_d         = c_q;
      in_cnt_d    = in_cnt_q;
      out_idx_d   = out_idx_q;
      sat_d       = sat_q;
      v1_d        = v1_q;
      out_valid_d = out_valid_q;
      cp_d        = cp_q;
      sq_d        = sq_q;
      sp_d        = sp_q;
      cq_d        = cq_q;
      out_p_d     = out_p_q;
      out_q_d     = out_q_q;

      if (in_hs)
         in_cnt_d = in_cnt_q + CW'(1);
      if (out_hs)
         out_idx_d = (out_idx_q == LAST_IDX) ? '0 : out_idx_q + IW'(1);

      // A stall freezes both pipeline stages together.
      if (!stall) begin
         v1_d = in_hs;
         if (in_hs) begin
            cp_d = c_x * p_x;
            sq_d = s_x * q_x;
            sp_d = s_x * p_x;
            cq_d = c_x * q_x;
         end
         out_valid_d = v1_q;
         if (v1_q) begin
            out_p_d = res_p[DATA_W-1:0];
            out_q_d = res_q[DATA_W-1:0];
            sat_d   = sat_q | res_p[DATA_W] | res_q[DATA_W];
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (ready_for_givens) begin
               s_d       = sin;
               c_d       = cos;
               in_cnt_d  = '0;
               out_idx_d = '0;
               sat_d     = 1'b0;
               state_d   = ST_ROTATE;
            end
         end
         ST_ROTATE: begin
            if (out_hs && (out_idx_q == LAST_IDX))
               state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         c_q         <= '0;
         in_cnt_q    <= '0;
         out_idx_q   <= '0;
         sat_q       <= 1'b0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         cp_q        <= '0;
         sq_q        <= '0;
         sp_q        <= '0;
         cq_q        <= '0;
         out_p_q     <= '0;
         out_q_q     <= '0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         c_q         <= c_d;
         in_cnt_q    <= in_cnt_d;
         out_idx_q   <= out_idx_d;
         sat_q       <= sat_d;
         v1_q        <= v1_d;
         out_valid_q <= out_valid_d;
         cp_q        <= cp_d;
         sq_q        <= sq_d;
         sp_q        <= sp_d;
         cq_q        <= cq_d;
         out_p_q     <= out_p_d;
         out_q_q     <= out_q_d;
      end
   end

   assign st.in_ready  = in_ready_w;
   assign st.out_valid = out_valid_q;
   assign st.out_p     = out_p_q;
   assign st.out_q     = out_q_q;
   assign st.out_idx   = out_idx_q;
   assign busy         = (state_q == ST_ROTATE);
   assign done         = (state_q == ST_DONE);
   assign sat_flag     = sat_q;
endmodule

// File: tb/tb_givens_rotator.sv
// tb/tb_givens_rotator.sv - scoreboard bench for givens_rotator
module tb_givens_rotator;
   localparam int N = 8;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [31:0] sin = '0;
   logic signed [31:0] cos = '0;
   logic               ready_for_givens = 1'b0;
   logic               busy, done, sat_flag;

   givens_rotator_if #(.N(N), .DATA_W(32)) bus ();

   givens_rotator #(.N(N), .DATA_W(32), .CS_FRAC(30)) dut (
      .clk(clk), .reset(reset), .sin(sin), .cos(cos),
      .ready_for_givens(ready_for_givens), .st(bus.slave),
      .busy(busy), .done(done), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [31:0] p;
      logic signed [31:0] q;
      logic [2:0]         idx;
   } exp_t;

   exp_t               sb[$];
   exp_t               e;
   int                 checks = 0;
   int                 errors = 0;
   int                 cyc = 0;
   int                 push_idx = 0;
   int                 first_in = -1;
   int                 first_out = -1;
   int                 done_cnt = 0;
   logic signed [31:0] exp_s = '0;
   logic signed [31:0] exp_c = '0;
   bit                 hold_v = 0;
   logic signed [31:0] held_p, held_q;
   logic [2:0]         held_idx;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   // a*x +/- b*y in Q2.30, rounded half up, clamped to 32-bit signed
   function automatic logic signed [31:0] model(input logic signed [31:0] a, x, b, y, input bit sub);
      logic signed [95:0] acc;
      acc = 96'(a) * 96'(x);
      if (sub) acc = acc - 96'(b) * 96'(y);
      else     acc = acc + 96'(b) * 96'(y);
      acc = (acc + 96'sd536870912) >>> 30;
      if (acc > 96'sd2147483647)  return 32'h7FFFFFFF;
      if (acc < -96'sd2147483648) return 32'h80000000;
      return acc[31:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out_valid && bus.out_ready) begin
            if (first_out < 0) first_out = cyc;
            chk("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("out_p", bus.out_p, e.p);
               chk("out_q", bus.out_q, e.q);
               chk("out_idx", bus.out_idx, e.idx);
            end
         end
         if (bus.out_valid && !bus.out_ready) begin
            if (hold_v) begin
               chk("hold_p", bus.out_p, held_p);
               chk("hold_q", bus.out_q, held_q);
               chk("hold_idx", bus.out_idx, held_idx);
            end
            chk("stall_in_ready", bus.in_ready, 0);
            hold_v   = 1;
            held_p   = bus.out_p;
            held_q   = bus.out_q;
            held_idx = bus.out_idx;
         end else begin
            hold_v = 0;
         end
         if (bus.in_valid && bus.in_ready) begin
            if (first_in < 0) first_in = cyc;
            e.p   = model(exp_c, bus.in_p, exp_s, bus.in_q, 1'b1);
            e.q   = model(exp_s, bus.in_p, exp_c, bus.in_q, 1'b0);
            e.idx = push_idx[2:0];
            sb.push_back(e);
            push_idx = (push_idx + 1) % N;
         end
         if (done) done_cnt++;
      end
   end

   task automatic strobe(input logic signed [31:0] s, input logic signed [31:0] c);
      exp_s     = s;
      exp_c     = c;
      first_in  = -1;
      first_out = -1;
      done_cnt  = 0;
      push_idx  = 0;
      sin = s;
      cos = c;
      ready_for_givens = 1'b1;
      @(posedge clk); #1;
      ready_for_givens = 1'b0;
   endtask

   task automatic send_pair(input logic signed [31:0] p, input logic signed [31:0] q);
      int g;
      bit acc;
      g   = 0;
      acc = 0;
      bus.in_valid = 1'b1;
      bus.in_p     = p;
      bus.in_q     = q;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
         g++;
      end while (!acc && g < 100);
      bus.in_valid = 1'b0;
      chk("in_accept", 64'(acc), 1);
   endtask

   task automatic wait_done(input string tag);
      int g;
      g = 0;
      while (done_cnt == 0 && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_once"}, done_cnt, 1);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_busy_low"}, busy, 0);
      chk({tag, "_idx_wrap"}, bus.out_idx, 0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_p      = '0;
      bus.in_q      = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_p", bus.out_p, 0);
      chk("rst_out_q", bus.out_q, 0);
      chk("rst_out_idx", bus.out_idx, 0);

      // in_valid in IDLE must not be accepted
      bus.in_valid = 1'b1;
      bus.in_p     = 32'sd9;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("idle_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;

      // identity
      strobe(32'sh0, 32'sh40000000);
      chk("busy_rotate", busy, 1);
      for (int k = 0; k < N; k++) send_pair(k, -k);
      wait_done("ident");
      chk("latency", first_out - first_in, 2);
      chk("ident_sat", sat_flag, 0);

      // 90 degrees
      strobe(32'sh40000000, 32'sh0);
      send_pair(32'sd5, 32'sd3);
      for (int k = 1; k < N; k++) send_pair(k * 1000, -k * 77);
      wait_done("rot90");

      // 45 degrees
      strobe(32'sh2D413CCD, 32'sh2D413CCD);
      send_pair(32'sd1000, 32'sd0);
      for (int k = 1; k < N; k++) send_pair(k * 123457 - 400000, 98765 - k * 31337);
      wait_done("rot45");

      // saturation, sticky through IDLE
      strobe(32'sh40000000, 32'sh40000000);
      for (int k = 0; k < N; k++) send_pair(32'sh7FFFFFFF, 32'sh7FFFFFFF);
      wait_done("sat");
      chk("sat_set", sat_flag, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("sat_sticky", sat_flag, 1);

      // strobe during ROTATE ignored; new strobe clears sat_flag
      strobe(32'sh187DE2A7, 32'sh3B20D79E);
      chk("sat_cleared", sat_flag, 0);
      fork
         for (int k = 0; k < N; k++) send_pair(k * 5000 + 17, 3000 - k * 911);
         begin
            repeat (3) @(posedge clk);
            #1;
            sin = 32'sh40000000;
            cos = 32'sh0;
            ready_for_givens = 1'b1;
            @(posedge clk); #1;
            ready_for_givens = 1'b0;
         end
      join
      wait_done("ignore_strobe");

      // backpressure mid-stream
      strobe(32'shE7821D59, 32'sh3B20D79E);
      fork
         for (int k = 0; k < N; k++) send_pair(-k * 4242 + 1, k * 777 - 5);
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      wait_done("bp");

      // reset after 3 pairs, then restart
      strobe(32'sh0, 32'sh40000000);
      for (int k = 0; k < 3; k++) send_pair(k + 100, k - 100);
      reset = 1'b1;
      @(posedge clk); #1;
      reset  = 1'b0;
      hold_v = 0;
      sb.delete();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_out_idx", bus.out_idx, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_quiet", bus.out_valid, 0);
      strobe(32'sh40000000, 32'sh0);
      for (int k = 0; k < N; k++) send_pair(k * 3 - 7, k * 11 + 2);
      wait_done("restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
